// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared RAM controller constants and FSM state type
package ram_ctrl_pkg;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin arbiter with request masking
module rr_arb2 (
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       last,
   output logic [1:0] grant,
   output logic       any
);

   logic [1:0] elig;

   assign elig = req & ~mask;
   assign any  = |elig;

   // On contention the client that did not win last time gets the grant.
   always_comb begin
      grant = 2'b00;
      if (elig == 2'b11)
         grant = last ? 2'b01 : 2'b10;
      else
         grant = elig;
   end

endmodule

// File: rtl/ram_arbiter_2.sv
// rtl/ram_arbiter_2.sv - serialises two clients onto a single-port RAM with registered pins
module ram_arbiter_2 #(
   parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
   parameter int DATA_W = ram_ctrl_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_wr,
   output logic              ram_cs,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   import ram_ctrl_pkg::*;

   state_t     state;
   logic       last;
   logic [1:0] grant;
   logic       any;

   // The client currently holding an ACC cycle still shows its stale request; mask it.
   rr_arb2 u_arb (
      .req   ({req1, req0}),
      .mask  ({gnt1, gnt0}),
      .last  (last),
      .grant (grant),
      .any   (any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
         ram_addr <= '0;
         ram_din  <= '0;
         ram_wr   <= 1'b0;
         ram_cs   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         gnt0    <= grant[0];
         gnt1    <= grant[1];
         busy    <= any;
         rvalid0 <= (state == ACC0) && !ram_wr;
         rvalid1 <= (state == ACC1) && !ram_wr;
         if ((state == ACC0) && !ram_wr)
            rdata0 <= ram_dout;
         if ((state == ACC1) && !ram_wr)
            rdata1 <= ram_dout;

         if (grant[0]) begin
            state    <= ACC0;
            last     <= 1'b0;
            ram_addr <= addr0;
            ram_din  <= wdata0;
            ram_wr   <= wr0;
            ram_cs   <= 1'b1;
         end else if (grant[1]) begin
            state    <= ACC1;
            last     <= 1'b1;
            ram_addr <= addr1;
            ram_din  <= wdata1;
            ram_wr   <= wr1;
            ram_cs   <= 1'b1;
         end else begin
            state  <= IDLE;
            ram_wr <= 1'b0;
            ram_cs <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter_2.sv
// tb/tb_ram_arbiter_2.sv - scoreboard bench for ram_arbiter_2 with a behavioural RAM
module tb_ram_arbiter_2;

   logic       clk;
   logic       rst;
   logic       req0, wr0, req1, wr1;
   logic [9:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, rvalid0, gnt1, rvalid1;
   logic [7:0] rdata0, rdata1;
   logic [9:0] ram_addr;
   logic [7:0] ram_din, ram_dout;
   logic       ram_wr, ram_cs, busy;

   logic [7:0] mem [0:ram_ctrl_pkg::MEM_DEPTH-1];

   int         n_cmp;
   int         n_bad;
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int         gnt_log [$];

   ram_arbiter_2 dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .wr0      (wr0),
      .addr0    (addr0),
      .wdata0   (wdata0),
      .gnt0     (gnt0),
      .rvalid0  (rvalid0),
      .rdata0   (rdata0),
      .req1     (req1),
      .wr1      (wr1),
      .addr1    (addr1),
      .wdata1   (wdata1),
      .gnt1     (gnt1),
      .rvalid1  (rvalid1),
      .rdata1   (rdata1),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_wr   (ram_wr),
      .ram_cs   (ram_cs),
      .ram_dout (ram_dout),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ram_dout = mem[ram_addr];
   always @(posedge clk)
      if (ram_cs && ram_wr)
         mem[ram_addr] <= ram_din;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expected read data on rvalid and logs grant order.
   always @(negedge clk) begin
      if (rvalid0) begin
         if (q0.size() == 0) check("rvalid0_unexpected", 1, 0);
         else check("rdata0", rdata0, q0.pop_front());
      end
      if (rvalid1) begin
         if (q1.size() == 0) check("rvalid1_unexpected", 1, 0);
         else check("rdata1", rdata1, q1.pop_front());
      end
      if (gnt0 || gnt1) begin
         check("gnt_exclusive", gnt0 & gnt1, 0);
         gnt_log.push_back(gnt1 ? 1 : 0);
      end
      if (ram_wr) check("wr_implies_cs", ram_cs, 1);
   end

   task automatic txn0(input logic w, input logic [9:0] a, input logic [7:0] d,
                       input logic [7:0] exp, output int n);
      req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
      if (!w) q0.push_back(exp);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (gnt0) begin n = i; break; end
      end
      if (n == 0) check("gnt0_timeout", 0, 1);
      req0 = 1'b0;
   endtask

   task automatic txn1(input logic w, input logic [9:0] a, input logic [7:0] d,
                       input logic [7:0] exp, output int n);
      req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
      if (!w) q1.push_back(exp);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (gnt1) begin n = i; break; end
      end
      if (n == 0) check("gnt1_timeout", 0, 1);
      req1 = 1'b0;
   endtask

   initial begin
      int n, m;
      n_cmp = 0; n_bad = 0;
      for (int i = 0; i < ram_ctrl_pkg::MEM_DEPTH; i++) mem[i] = 8'h00;
      rst = 1'b1;
      req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;

      // Reset then idle
      tick(); tick();
      check("reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, ram_wr, ram_cs, busy}, 0);
      check("reset_data", {rdata0, rdata1, ram_addr, ram_din}, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_quiet", {gnt0, gnt1, rvalid0, rvalid1, ram_wr, ram_cs, busy}, 0);
      end

      // Single write then read, client 0
      txn0(1'b1, 10'h155, 8'hA5, 8'h00, n);
      check("wr_gnt_latency", n, 1);
      check("wr_pins", {ram_cs, ram_wr, ram_addr, ram_din}, {1'b1, 1'b1, 10'h155, 8'hA5});
      check("wr_busy", busy, 1);
      tick();
      check("after_wr_idle", {ram_cs, ram_wr, rvalid0}, 0);
      txn0(1'b0, 10'h155, 8'h00, 8'hA5, n);
      check("rd_gnt_latency", n, 1);
      check("rd_pins", {ram_cs, ram_wr, ram_addr}, {1'b1, 1'b0, 10'h155});
      tick();
      check("rd_rvalid_latency", rvalid0, 1);

      // Contention straight out of reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0 = 1; wr0 = 0; addr0 = 10'h155;
      req1 = 1; wr1 = 0; addr1 = 10'h155;
      q0.push_back(8'hA5); q1.push_back(8'hA5);
      tick();
      check("cont_c1", {gnt0, gnt1}, 2'b10);
      req0 = 0;
      tick();
      check("cont_c2", {gnt0, gnt1, rvalid0}, 3'b011);
      req1 = 0;
      tick();
      check("cont_c3", {gnt0, gnt1, rvalid1}, 3'b001);
      tick();

      // Sustained contention
      gnt_log.delete();
      fork
         begin
            int k;
            for (int i = 0; i < 4; i++) txn0(1'b0, 10'h155, 8'h00, 8'hA5, k);
         end
         begin
            int k;
            for (int i = 0; i < 4; i++) txn1(1'b0, 10'h155, 8'h00, 8'hA5, k);
         end
      join
      tick(); tick();
      check("sustained_count", gnt_log.size(), 8);
      for (int i = 1; i < gnt_log.size(); i++)
         check("sustained_alternate", gnt_log[i] ^ gnt_log[i-1], 1);

      // Address boundaries
      fork
         txn1(1'b1, 10'h3FF, 8'h11, 8'h00, n);
         txn0(1'b1, 10'h000, 8'h22, 8'h00, m);
      join
      tick();
      fork
         txn1(1'b0, 10'h3FF, 8'h00, 8'h11, n);
         txn0(1'b0, 10'h000, 8'h00, 8'h22, m);
      join
      tick(); tick();
      check("bound_rdata1", rdata1, 8'h11);
      check("bound_rdata0", rdata0, 8'h22);

      // Reset during an ACC1 read: no rvalid may follow
      req1 = 1; wr1 = 0; addr1 = 10'h3FF;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (gnt1) begin n = i; break; end
      end
      check("pre_reset_gnt1", n, 1);
      rst = 1'b1; req1 = 0;
      tick();
      check("rst_acc_pins", {ram_cs, ram_wr, rvalid1, gnt1, busy}, 0);
      check("rst_acc_rdata1", rdata1, 0);
      rst = 1'b0;
      gnt_log.delete();
      fork
         txn0(1'b0, 10'h000, 8'h00, 8'h22, n);
         txn1(1'b0, 10'h3FF, 8'h00, 8'h11, m);
      join
      tick(); tick();
      check("post_reset_first", gnt_log.size() > 0 ? gnt_log[0] : 9, 0);
      check("post_reset_rvalid1_quiet", rvalid1, 0);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_arbiter_2.md
Name: ram_arbiter_2

Overview:
- Two-requester, round-robin access controller for the single-port 1024x8 RAM.
- The RAM has an asynchronous read and a level-sensitive write.
- This block serialises the two clients' read/write transactions onto the RAM's addr/data_in/wr/cs pins and returns read data with a valid pulse.
- It sits between client logic and the RAM instance; every RAM pin is driven from a register.

Parameters:
ADDR_W, 10, RAM address width
DATA_W, 8, RAM word width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req0  in  1  client 0 request; held until gnt0
wr0  in  1  client 0: 1=write, 0=read; stable while req0
addr0  in  ADDR_W  client 0 address; stable while req0
wdata0  in  DATA_W  client 0 write data; stable while req0
gnt0  out  1  one-cycle pulse: client 0 transaction being performed this cycle
rvalid0  out  1  one-cycle pulse: rdata0 holds read result
rdata0  out  DATA_W  client 0 read data; holds last value
req1, wr1, addr1, wdata1, gnt1, rvalid1, rdata1  same as client 0, for client 1
ram_addr  out  ADDR_W  to RAM addr
ram_din  out  DATA_W  to RAM data_in
ram_wr  out  1  to RAM wr
ram_cs  out  1  to RAM cs
ram_dout  in  DATA_W  from RAM data_out (combinational)
busy  out  1  high in any ACC state

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, last=1 (client 0 wins the first contention).
  - gnt*, rvalid*, ram_wr, ram_cs, busy = 0.
  - ram_addr, ram_din, rdata0, rdata1 = 0.
- Reset mid-ACC:
  - The access is aborted; no rvalid is issued; ram_wr/ram_cs drop on the reset edge.
  - A write whose ACC cycle was already driven may have landed; this is acceptable.
- FSM states: IDLE, ACC0, ACC1.
- Arbitration, every edge where state is IDLE or ACCx:
  - Eligible: req0 and req1, excluding the client whose gnt is high this cycle. This prevents a double grant on a stale request.
  - Both eligible: grant the client != last.
  - One eligible: grant that client.
  - None eligible: next state IDLE.
- On a grant to client k:
  - next state ACCk; gnt_k=1 for that cycle only; last<=k; busy=1.
  - ram_addr<=addr_k, ram_din<=wdata_k, ram_wr<=wr_k, ram_cs<=1.
- On leaving ACC to IDLE: ram_cs<=0, ram_wr<=0; ram_addr/ram_din hold.
- ram_wr is never high outside an ACC cycle. One transaction occupies exactly one ACC cycle.
- Read capture:
  - At the edge ending ACCk with ram_wr=0: rdata_k<=ram_dout and rvalid_k<=1 for one cycle.
  - Writes produce no rvalid. rdata_k is otherwise unchanged.
- Latency:
  - req high in cycle 0 (IDLE) -> gnt in cycle 1 (ACC) -> rvalid in cycle 2.
  - Back-to-back alternation gives full throughput: ACC0, ACC1, ACC0, ...
  - A single client streaming alone gets one access every 2 cycles (ACC, IDLE, ACC).
- Handshake:
  - The client holds req/wr/addr/wdata until it samples gnt high.
  - It may present a new transaction the cycle after gnt.
  - Dropping req before gnt withdraws the request; this is legal.
- rvalid_k and gnt_j may be high in the same cycle.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - ADDR_W=10, DATA_W=8, MEM_DEPTH=1024.
  - state enum {IDLE, ACC0, ACC1}.
- One natural sub-module: rr_arb2. It is combinational.
  - Inputs: req[1:0], mask[1:0], last.
  - Outputs: onehot grant[1:0] and any.
  - Reusable by future multi-client RAM controllers.
- The FSM, RAM pin registers and read capture stay in ram_arbiter_2.

Test Plan:
- Reset then idle:
  - Hold rst 2 cycles, then no reqs for 5 cycles.
  - Required: all outputs 0; ram_cs=0 throughout.
- Single write then read, client 0:
  - Write: req0=1, wr0=1, addr0=0x155, wdata0=0xA5.
    - gnt0 in cycle 1 with ram_cs=1, ram_wr=1, ram_addr=0x155, ram_din=0xA5.
  - Read: then issue a read of 0x155.
    - gnt0 with ram_wr=0; the next cycle rvalid0=1, rdata0=0xA5.
- Contention from reset:
  - req0 and req1 both rise in the same cycle, both reads.
  - Required: gnt0 cycle 1, gnt1 cycle 2, rvalid0 cycle 2, rvalid1 cycle 3; no IDLE gap.
- Sustained contention, 8 cycles with both clients re-requesting after each gnt:
  - Required: strict alternation of grants, 0,1,0,1,...
  - Required: no cycle with gnt0 and gnt1 both high.
- Address boundaries:
  - Write 0x3FF=0x11 via client 1 and 0x000=0x22 via client 0, then read both.
  - Required: rdata1=0x11, rdata0=0x22; no aliasing.
- Reset during ACC1 read:
  - Assert rst in the cycle gnt1=1.
  - Required: the next cycle has ram_cs=0, rvalid1=0 and state IDLE.
  - Required: the first contention afterwards grants client 0.
